timer_ctrl: RTL and testbench

- Parametrised successor to the team's free-running 8-bit counter.
- Adds configurable width, a programmable prescaler, a compare match, one-shot and periodic modes, synchronous load and a sticky interrupt flag.
- Sits beside the CPU core as a memory-mapped timer backend; the bus wrapper drives the control inputs and samples the status outputs.

---
 rtl/timer_ctrl.sv | 91 +++++++++
 tb/tb_timer_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Prescaled compare timer with one-shot and periodic modes, a synchronous load
// and a sticky match interrupt.
module timer_ctrl #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   cmp_val,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               irq_clr,
  output logic [WIDTH-1:0]   count,
  output logic               irq,
  output logic               running,
  output logic               match_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_count;
  logic [PRESC_W-1:0] r_presc;
  logic               r_mode, r_irq, r_match, r_running;
  logic               w_active, w_tick, w_match, w_start_ok;

  // stop dominates everything in its cycle, including a pending tick.
  assign w_active   = (r_state == S_RUN) && !stop;
  assign w_tick     = w_active && (r_presc == presc_div);
  assign w_match    = w_tick && !load && (r_count == cmp_val);
  assign w_start_ok = start && !stop && (r_state != S_RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_RUN;
        S_RUN:   if (w_match && !r_mode) w_next = S_DONE;
        S_DONE:  if (start) w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= '0;
      r_presc   <= '0;
      r_mode    <= 1'b0;
      r_irq     <= 1'b0;
      r_match   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_running <= (w_next == S_RUN);
      r_match   <= w_match;

      if (w_match)      r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;

      if (w_start_ok) r_mode <= mode;

      // A presc_div lowered below r_presc lets the counter wrap around.
      if (w_active) r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
      else          r_presc <= '0;

      // load wins over the tick; a one-shot match simply holds the count.
      if (load)         r_count <= load_val;
      else if (w_match) begin
        if (r_mode) r_count <= '0;
      end
      else if (w_tick)  r_count <= r_count + WIDTH'(1);
    end
  end

  assign count       = r_count;
  assign irq         = r_irq;
  assign running     = r_running;
  assign match_pulse = r_match;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed plus randomized bench for timer_ctrl against a cycle-level
// behavioural model of the timer rules.
module tb_timer_ctrl;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0, resetn = 1'b1;
  logic          start = 1'b0, stop = 1'b0, mode = 1'b0, load = 1'b0, irq_clr = 1'b0;
  logic [W-1:0]  load_val = '0, cmp_val = '0;
  logic [PW-1:0] presc_div = '0;
  logic [W-1:0]  count;
  logic          irq, running, match_pulse;

  int n_vec = 0, n_miss = 0;

  // Model: is the timer counting, its mode, count, prescale phase, flags.
  int m_cnt, m_pc;
  bit m_run, m_per, m_irq, m_mp;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .mode(mode),
    .load(load), .load_val(load_val), .cmp_val(cmp_val), .presc_div(presc_div),
    .irq_clr(irq_clr), .count(count), .irq(irq), .running(running),
    .match_pulse(match_pulse)
  );

  task automatic model_reset();
    m_cnt = 0; m_pc = 0; m_run = 0; m_per = 0; m_irq = 0; m_mp = 0;
  endtask

  task automatic model_step();
    bit tick, hit;
    if (!resetn) begin model_reset(); return; end
    tick = m_run && !stop && (m_pc == int'(presc_div));
    hit  = tick && !load && (m_cnt == int'(cmp_val));
    m_mp = hit;
    if (hit) m_irq = 1; else if (irq_clr) m_irq = 0;
    if (load)         m_cnt = int'(load_val);
    else if (hit)     m_cnt = m_per ? 0 : m_cnt;
    else if (tick)    m_cnt = (m_cnt + 1) % (1 << W);
    m_pc = (m_run && !stop) ? (tick ? 0 : (m_pc + 1) % (1 << PW)) : 0;
    if (stop)                     m_run = 0;
    else if (start && !m_run)     begin m_run = 1; m_per = mode; end
    else if (hit && !m_per)       m_run = 0;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 64'(count), 64'(m_cnt));
    check("irq", 64'(irq), 64'(m_irq));
    check("running", 64'(running), 64'(m_run));
    check("match_pulse", 64'(match_pulse), 64'(m_mp));
  endtask

  // One clock: model steps on the edge, outputs sampled 1 time unit later,
  // then single-cycle pulse inputs drop.
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
      start = 0; stop = 0; load = 0; irq_clr = 0;
    end
  endtask

  initial begin
    model_reset();
    #1 resetn = 0;
    cyc(3);
    resetn = 1;
    cyc(10);

    // Periodic, every-cycle tick, compare 4.
    cmp_val = 4; presc_div = 0; mode = 1; start = 1;
    cyc(13);
    check("periodic_irq_sticky", 64'(irq), 64'd1);
    irq_clr = 1;
    cyc(1);
    check("periodic_irq_cleared", 64'(irq), 64'd0);
    cyc(4);

    // One-shot with prescaler 4.
    stop = 1; load = 1; load_val = 0;
    cyc(1);
    mode = 0; presc_div = 3; cmp_val = 2; start = 1;
    cyc(20);
    check("oneshot_hold", 64'(count), 64'd2);
    check("oneshot_stopped", 64'(running), 64'd0);
    start = 1;
    cyc(6);

    // Wrap through all-ones.
    stop = 1; load = 1; load_val = 8'hFE;
    cyc(1);
    cmp_val = 8'h01; mode = 1; presc_div = 0; start = 1;
    cyc(3);
    check("wrap_zero", 64'(count), 64'h00);
    cyc(4);

    // start and stop together.
    stop = 1;
    cyc(1);
    start = 1; stop = 1;
    cyc(1);
    check("start_stop_idle", 64'(running), 64'd0);
    cyc(3);

    // irq_clr on a match cycle: set wins.
    load = 1; load_val = 0; cmp_val = 4; mode = 1; presc_div = 0;
    start = 1; irq_clr = 1;
    cyc(1);
    for (int i = 0; i < 12; i++) begin
      if (m_cnt == 4 && m_run) begin
        irq_clr = 1;
        cyc(1);
        check("clr_vs_set", 64'(irq), 64'd1);
        break;
      end
      cyc(1);
    end

    // load on a match tick: load wins, no pulse.
    for (int i = 0; i < 12; i++) begin
      if (m_cnt == 4 && m_run) begin
        load = 1; load_val = 7;
        cyc(1);
        check("load_vs_match_cnt", 64'(count), 64'd7);
        check("load_vs_match_mp", 64'(match_pulse), 64'd0);
        break;
      end
      cyc(1);
    end
    cyc(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 19) == 0);
      irq_clr  = ($urandom_range(0, 7) == 0);
      mode     = $urandom_range(0, 1);
      load_val = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) cmp_val = W'($urandom_range(0, 20));
      if ($urandom_range(0, 31) == 0) presc_div = PW'($urandom_range(0, 3));
      cyc(1);
    end

    // Async reset between edges at count 3.
    stop = 1; load = 1; load_val = 0;
    cyc(1);
    cmp_val = 10; mode = 1; presc_div = 0; start = 1;
    cyc(1);
    for (int i = 0; i < 20 && count !== 3; i++) cyc(1);
    check("async_reach3", 64'(count), 64'd3);
    #2 resetn = 0;
    #1;
    model_reset();
    check("async_count", 64'(count), 64'd0);
    check("async_running", 64'(running), 64'd0);
    check("async_mp", 64'(match_pulse), 64'd0);
    cyc(2);
    resetn = 1;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
